// File: rtl/lab2_pkg.sv
// lab2_pkg: shared constants for the serial-code transmitter lab.
//   MSG        - the 16-element message, 4 bits per element
//   digit_e    - which display digit is currently lit
//   hex_glyph  - 4-bit value to active-low {g,f,e,d,c,b,a} segment pattern
package lab2_pkg;

  localparam int MSG_LEN = 16;

  localparam logic [3:0] MSG [MSG_LEN] = '{
    4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6,
    4'd5, 4'd3, 4'd5, 4'd8, 4'd9, 4'd7, 4'd9, 4'd3
  };

  // Digit order on the display: digit 0 is the rightmost anode (an[0]).
  typedef enum logic [1:0] {
    DIG_EL  = 2'd0,
    DIG_BIT = 2'd1,
    DIG_NOM = 2'd2
  } digit_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] value);
    logic [6:0] glyph;
    case (value)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer followed by a stable-level filter.
//   clk, rst_n - board clock, async active-low reset
//   tick       - divide-by-2 enable; nothing advances when low
//   raw        - raw push-button input (asynchronous)
//   level      - filtered level; flips only after the synchronized input
//                has disagreed with it for DEBOUNCE_TICKS consecutive ticks
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_TICKS = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level
);

  logic        sync_p0;
  logic        sync_p1;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else if (tick) begin
      // synchronizer stages
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // filter: any agreement restarts the count, so short glitches die here
      if (sync_p1 != level) begin
        if (cnt == DEBOUNCE_TICKS - 16'd1) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/seg_mux.sv
// seg_mux: time-multiplexes three hex nibbles onto a 3-digit 7-segment display.
//   clk, rst_n       - board clock, async active-low reset
//   tick             - divide-by-2 enable
//   dig0/dig1/dig2   - nibble shown on an[0]/an[1]/an[2]
//   seg              - active-low {g,f,e,d,c,b,a}, combinational from the lit digit
//   an               - active-low anodes, exactly one low at any time
module seg_mux
  import lab2_pkg::*;
#(
  parameter logic [15:0] SCAN_TICKS = 16'd10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  output logic [6:0] seg,
  output logic [2:0] an
);

  digit_e      sel;
  digit_e      sel_next;
  logic [15:0] scan_cnt;
  logic        scan_wrap;

  assign scan_wrap = (scan_cnt == SCAN_TICKS - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sel      <= DIG_EL;
    end else if (tick) begin
      scan_cnt <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
      sel      <= sel_next;
    end
  end

  always_comb begin
    sel_next = sel;
    an       = 3'b110;
    seg      = hex_glyph(dig0);
    case (sel)
      DIG_EL: begin
        an  = 3'b110;
        seg = hex_glyph(dig0);
        if (scan_wrap) sel_next = DIG_BIT;
      end
      DIG_BIT: begin
        an  = 3'b101;
        seg = hex_glyph(dig1);
        if (scan_wrap) sel_next = DIG_NOM;
      end
      DIG_NOM: begin
        an  = 3'b011;
        seg = hex_glyph(dig2);
        if (scan_wrap) sel_next = DIG_EL;
      end
      default: begin
        // unreachable encoding: recover to digit 0
        sel_next = DIG_EL;
      end
    endcase
  end

endmodule

// File: rtl/lab2_tx_top.sv
// lab2_tx_top: serial-code transmitter. Each debounced click on btnU steps
// one bit (LSB first) through a 16-element, 4-bit message; btnC clears the
// position back to element 0, bit 0.
//   clk    - board clock
//   rst_n  - async active-low reset
//   btnC   - raw clear button, active-high
//   btnU   - raw click button, active-high
//   seg    - active-low segments {g,f,e,d,c,b,a}
//   an     - active-low anodes: an[0]=element value, an[1]=bit, an[2]=element index
//   led    - led[0] is the currently transmitted bit
module lab2_tx_top
  import lab2_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_TICKS = 16'd50000,
  parameter logic [15:0] SCAN_TICKS     = 16'd10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnC,
  input  logic       btnU,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic [0:0] led
);

  logic       tick;
  logic       clr_level;
  logic       clk_level;
  logic       clk_level_d;
  logic       click;
  logic [3:0] nom;
  logic [1:0] bit_idx;
  logic [3:0] el;

  // divide-by-2 enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick <= 1'b0;
    else        tick <= ~tick;
  end

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .raw   (btnC),
    .level (clr_level)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_click (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .raw   (btnU),
    .level (clk_level)
  );

  // rising-edge detect on the filtered click level; holding gives one advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    clk_level_d <= 1'b0;
    else if (tick) clk_level_d <= clk_level;
  end

  assign click = clk_level & ~clk_level_d;

  // position counters; clear dominates a coincident click
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nom     <= '0;
      bit_idx <= '0;
    end else if (tick) begin
      if (clr_level) begin
        nom     <= '0;
        bit_idx <= '0;
      end else if (click) begin
        bit_idx <= bit_idx + 2'd1;
        if (bit_idx == 2'd3) nom <= nom + 4'd1;
      end
    end
  end

  assign el     = MSG[nom];
  assign led[0] = el[bit_idx];

  seg_mux #(.SCAN_TICKS(SCAN_TICKS)) u_seg_mux (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .dig0  (el),
    .dig1  ({2'b00, bit_idx}),
    .dig2  (nom),
    .seg   (seg),
    .an    (an)
  );

endmodule

// File: tb/tb_lab2_tx_top.sv
module tb_lab2_tx_top;

  localparam int DEB  = 4;
  localparam int SCAN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnC = 1'b0;
  logic       btnU = 1'b0;
  logic [6:0] seg;
  logic [2:0] an;
  logic [0:0] led;

  lab2_tx_top #(.DEBOUNCE_TICKS(16'(DEB)), .SCAN_TICKS(16'(SCAN))) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btnC  (btnC),
    .btnU  (btnU),
    .seg   (seg),
    .an    (an),
    .led   (led)
  );

  always #5 clk = ~clk;

  // reference data, written independently of the design package
  int msg   [16] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3, 5, 8, 9, 7, 9, 3};
  int glyph [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                     'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

  int errors = 0;
  int checks = 0;
  int pos    = 0;   // model position: element*4 + bit, 0..63
  int q[$];         // scoreboard: expected positions
  int edges  = 0;   // clock edges since reset release

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every enabled tick advances the scan, so the lit digit is
  // (ticks / SCAN) mod 3, with ticks = edges/2 after reset release.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      int p, n, b, e, d, v, exp_an;
      p = q.pop_front();
      n = p / 4;
      b = p % 4;
      e = msg[n];
      d = ((edges / 2) / SCAN) % 3;
      exp_an = (d == 0) ? 3'b110 : (d == 1) ? 3'b101 : 3'b011;
      v = (d == 0) ? e : (d == 1) ? b : n;
      chk("led", int'(led[0]), (e >> b) & 1);
      chk("an", int'(an), exp_an);
      chk("seg", int'(seg), glyph[v]);
    end
  end

  task automatic wait_ticks(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  task automatic expect_now();
    @(posedge clk);
    q.push_back(pos);
    @(negedge clk);
  endtask

  // check every cycle across a full display scan
  task automatic sweep();
    for (int i = 0; i < 6 * SCAN + 2; i++) begin
      @(posedge clk);
      q.push_back(pos);
    end
    @(negedge clk);
  endtask

  task automatic click();
    btnU = 1'b1;
    wait_ticks($urandom_range(8, 20));
    btnU = 1'b0;
    wait_ticks($urandom_range(8, 14));
    pos = (pos + 1) % 64;
  endtask

  initial begin
    // reset with random buttons
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btnC = 1'($urandom);
      btnU = 1'($urandom);
      q.push_back(pos);
    end
    @(negedge clk);
    btnC = 1'b0;
    btnU = 1'b0;
    rst_n = 1'b1;
    sweep();
    sweep();

    // short glitches never register
    for (int i = 0; i < 6; i++) begin
      btnU = 1'b1;
      wait_ticks($urandom_range(1, DEB - 1));
      btnU = 1'b0;
      wait_ticks(DEB + 3);
    end
    expect_now();

    // one 20-tick press, checked while still held and after a long hold
    btnU = 1'b1;
    wait_ticks(20);
    pos = 1;
    expect_now();
    wait_ticks(80);
    expect_now();
    btnU = 1'b0;
    wait_ticks(12);
    expect_now();

    // three more clicks reach element 1, bit 0
    for (int i = 0; i < 3; i++) click();
    sweep();

    // walk up to the last bit of the last element, then wrap
    for (int i = 0; i < 59; i++) click();
    expect_now();
    chk("wrap_pos63", pos, 63);
    click();
    sweep();

    // go to element 5, bit 2
    for (int i = 0; i < 22; i++) click();
    expect_now();

    // clear together with a click: clear wins
    btnC = 1'b1;
    btnU = 1'b1;
    wait_ticks(14);
    pos = 0;
    expect_now();
    btnC = 1'b0;
    btnU = 1'b0;
    wait_ticks(12);
    sweep();

    // random clicks, then a clear on its own
    for (int i = 0; i < 7; i++) click();
    expect_now();
    btnC = 1'b1;
    wait_ticks(10);
    pos = 0;
    expect_now();
    btnC = 1'b0;
    wait_ticks(10);
    for (int i = 0; i < 2; i++) click();
    expect_now();

    // async reset mid-scan: outputs return without a clock edge
    wait_ticks(SCAN + 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_an", int'(an), 3'b110);
    chk("rst_seg", int'(seg), 'h30);
    chk("rst_led", int'(led[0]), 1);
    pos = 0;
    wait_ticks(3);
    @(negedge clk);
    rst_n = 1'b1;
    sweep();

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
